// File: rtl/ppu_result_buffer.sv
// Result buffer between the PPU pipeline output and a ready/valid consumer.
// Raises stall early enough that results still in flight after stall asserts can be absorbed.
module ppu_result_buffer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned PIPE_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    stall_o,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    input  logic                    ready_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull     = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntThrottle = CntW'(DEPTH - PIPE_LATENCY);

    typedef enum logic [1:0] {
        StEmpty,
        StFlow,
        StThrottle,
        StFull
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q;
    logic                  push, pop, drop;

    always_comb begin
        pop  = (count_q != '0) && ready_i;
        // A pop in the same cycle frees the slot, so a full buffer can still accept.
        push = valid_i && ((count_q < CntFull) || pop);
        drop = valid_i && !push;
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next state follows next count so it may skip states in a single cycle.
    always_comb begin
        state_d = StFlow;
        if (count_d == '0) begin
            state_d = StEmpty;
        end else if (count_d == CntFull) begin
            state_d = StFull;
        end else if (count_d >= CntThrottle) begin
            state_d = StThrottle;
        end
        stall_o = (state_q == StThrottle) || (state_q == StFull);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o    = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ppu_result_buffer.sv
// Directed self-checking bench for ppu_result_buffer at DEPTH=8, PIPE_LATENCY=3, DATA_WIDTH=32.
module tb_ppu_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] data_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic [3:0]  count_o;
    logic        overflow_o;

    int compared   = 0;
    int mismatched = 0;

    ppu_result_buffer #(
        .DATA_WIDTH  (32),
        .DEPTH       (8),
        .PIPE_LATENCY(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .count_o   (count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Outputs are registered-only, so sampling 1 time unit after the edge is safe.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input int n);
        ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b1; data_i = base + 32'(i);
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 32'h1234;
        tick(); tick();
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        compared++;
        if (valid_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_valid: got %b expected 0", valid_o);
        end
        compared++;
        if (stall_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_stall: got %b expected 0", stall_o);
        end
        compared++;
        if (count_o !== 4'd0) begin
            mismatched++; $display("FAIL reset_count: got %0d expected 0", count_o);
        end
        compared++;
        if (overflow_o !== 1'b0) begin
            mismatched++; $display("FAIL reset_overflow: got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_basic_flow();
        valid_i = 1'b1; data_i = 32'hA5A5_0001; ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        compared++;
        if (valid_o !== 1'b1) begin
            mismatched++; $display("FAIL basic_valid: got %b expected 1", valid_o);
        end
        compared++;
        if (data_o !== 32'hA5A5_0001) begin
            mismatched++; $display("FAIL basic_data: got %h expected a5a50001", data_o);
        end
        tick();
        ready_i = 1'b0;
        compared++;
        if (count_o !== 4'd0) begin
            mismatched++; $display("FAIL basic_count_after_pop: got %0d expected 0", count_o);
        end
        compared++;
        if (valid_o !== 1'b0) begin
            mismatched++; $display("FAIL basic_valid_after_pop: got %b expected 0", valid_o);
        end
    endtask

    task automatic test_empty_pop();
        ready_i = 1'b1;
        tick(); tick();
        ready_i = 1'b0;
        compared++;
        if (count_o !== 4'd0) begin
            mismatched++; $display("FAIL empty_pop_count: got %0d expected 0", count_o);
        end
        valid_i = 1'b1; data_i = 32'h77;
        tick();
        valid_i = 1'b0;
        compared++;
        if (data_o !== 32'h77) begin
            mismatched++; $display("FAIL empty_pop_ptr: got %h expected 77", data_o);
        end
        do_reset();
    endtask

    task automatic test_throttle();
        fill(32'h10, 4);
        compared++;
        if (stall_o !== 1'b0 || count_o !== 4'd4) begin
            mismatched++;
            $display("FAIL throttle_4: got stall=%b count=%0d expected stall=0 count=4",
                     stall_o, count_o);
        end
        fill(32'h14, 1);
        compared++;
        if (stall_o !== 1'b1 || count_o !== 4'd5) begin
            mismatched++;
            $display("FAIL throttle_5: got stall=%b count=%0d expected stall=1 count=5",
                     stall_o, count_o);
        end
        fill(32'h15, 3);
        compared++;
        if (count_o !== 4'd8 || stall_o !== 1'b1 || overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL throttle_full: got count=%0d stall=%b ovf=%b expected 8 1 0",
                     count_o, stall_o, overflow_o);
        end
    endtask

    task automatic test_overflow();
        ready_i = 1'b0; valid_i = 1'b1; data_i = 32'hDEAD;
        tick();
        valid_i = 1'b0;
        compared++;
        if (count_o !== 4'd8 || overflow_o !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow_set: got count=%0d ovf=%b expected 8 1", count_o, overflow_o);
        end
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (valid_o !== 1'b1 || data_o !== 32'h10 + 32'(i)) begin
                mismatched++;
                $display("FAIL overflow_drain[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, valid_o, data_o, 32'h10 + 32'(i));
            end
            tick();
        end
        ready_i = 1'b0;
        compared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            mismatched++;
            $display("FAIL overflow_after_drain: got count=%0d v=%b ovf=%b expected 0 0 1",
                     count_o, valid_o, overflow_o);
        end
        tick(); tick();
        compared++;
        if (overflow_o !== 1'b1) begin
            mismatched++; $display("FAIL overflow_sticky: got %b expected 1", overflow_o);
        end
        do_reset();
        compared++;
        if (overflow_o !== 1'b0) begin
            mismatched++; $display("FAIL overflow_cleared: got %b expected 0", overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_seq [8];
        fill(32'h10, 8);
        valid_i = 1'b1; data_i = 32'h99; ready_i = 1'b1;
        tick();
        valid_i = 1'b0; ready_i = 1'b0;
        compared++;
        if (count_o !== 4'd8 || overflow_o !== 1'b0 || data_o !== 32'h11) begin
            mismatched++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h expected 8 0 11",
                     count_o, overflow_o, data_o);
        end
        for (int i = 0; i < 7; i++) exp_seq[i] = 32'h11 + 32'(i);
        exp_seq[7] = 32'h99;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (data_o !== exp_seq[i]) begin
                mismatched++;
                $display("FAIL full_push_pop_drain[%0d]: got %h expected %h",
                         i, data_o, exp_seq[i]);
            end
            tick();
        end
        ready_i = 1'b0;
        do_reset();
    endtask

    task automatic test_wrap_stream();
        logic [31:0] model [$];
        int sent = 0;
        int rcvd = 0;
        for (int cyc = 0; cyc < 200 && rcvd < 20; cyc++) begin
            compared++;
            if (count_o !== 4'(model.size()) || count_o > 4'd8) begin
                mismatched++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", cyc, count_o, model.size());
            end
            ready_i = (cyc % 2 == 0);
            if (valid_o && ready_i && model.size() != 0) begin
                compared++;
                if (data_o !== model[0]) begin
                    mismatched++;
                    $display("FAIL wrap_order[%0d]: got %h expected %h", rcvd, data_o, model[0]);
                end
                void'(model.pop_front());
                rcvd++;
            end
            if (sent < 20 && !stall_o) begin
                valid_i = 1'b1; data_i = 32'h100 + 32'(sent);
                model.push_back(data_i);
                sent++;
            end else begin
                valid_i = 1'b0;
            end
            tick();
        end
        valid_i = 1'b0; ready_i = 1'b0;
        compared++;
        if (rcvd != 20) begin
            mismatched++; $display("FAIL wrap_received: got %0d expected 20", rcvd);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        fill(32'h40, 6);
        compared++;
        if (count_o !== 4'd6) begin
            mismatched++; $display("FAIL mid_reset_pre: got %0d expected 6", count_o);
        end
        valid_i = 1'b1; data_i = 32'hDEAD; ready_i = 1'b0;
        tick(); tick(); tick();
        valid_i = 1'b1; ready_i = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        compared++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || stall_o !== 1'b0 || overflow_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset: got count=%0d v=%b stall=%b ovf=%b expected 0 0 0 0",
                     count_o, valid_o, stall_o, overflow_o);
        end
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
        test_reset();
        test_basic_flow();
        test_empty_pop();
        test_throttle();
        test_overflow();
        test_full_push_pop();
        test_wrap_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
